// File: rtl/bitwise_logic_serial.sv
// bitwise_logic_serial
// Multi-cycle bitwise logic unit (AND / OR / XOR / ANDN). The operands are
// consumed CHUNK bits per clock through one CHUNK-wide logic slice. The
// result and a zero flag are returned through a valid/ready handshake.
module bitwise_logic_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] out_r;
    logic             zero_r;
    logic             out_valid_r;

    logic [CHUNK-1:0] slice_s;
    logic [WIDTH-1:0] acc_next_s;

    // One CHUNK-wide slice of the selected bitwise operation.
    function automatic logic [CHUNK-1:0] logic_slice(
        input logic [1:0]       sel,
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y
    );
        logic [CHUNK-1:0] r;
        case (sel)
            2'b00:   r = x & y;
            2'b01:   r = x | y;
            2'b10:   r = x ^ y;
            2'b11:   r = x & ~y;
            default: r = {CHUNK{1'b0}};
        endcase
        return r;
    endfunction

    // Slice datapath: evaluate the low chunk and merge it into the MSB end of the result.
    always_comb begin
        slice_s    = logic_slice(op_r, a_r[CHUNK-1:0], b_r[CHUNK-1:0]);
        acc_next_s = (WIDTH'(slice_s) << (WIDTH - CHUNK)) | (acc_r >> CHUNK);
    end

    // Control FSM with operand/result shift registers and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            op_r        <= 2'b00;
            acc_r       <= {WIDTH{1'b0}};
            out_r       <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= num1;
                        b_r     <= num2;
                        op_r    <= op;
                        acc_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    acc_r <= acc_next_s;
                    if (cnt_r == CW'(N - 1)) begin
                        // Counter holds at N-1; it is cleared on the next accept.
                        out_r       <= acc_next_s;
                        zero_r      <= (acc_next_s == {WIDTH{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Accept only in IDLE and never while reset is asserted.
    assign in_ready  = reset_n & (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_bitwise_logic_serial.sv
// Scoreboard bench for bitwise_logic_serial: one 32/8 instance for the
// functional tests plus 8/8, 12/4 and 4/1 instances for the parameter sweep.
module tb_bitwise_logic_serial;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic [31:0] due;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] n1 [4];
    logic [31:0] n2 [4];
    logic [1:0]  opv [4];
    logic        iv [4];
    wire         rdy [4];
    wire         ov [4];
    wire         zr [4];
    wire  [31:0] res_w [4];
    wire  [31:0] o0;
    wire  [7:0]  o1;
    wire  [11:0] o2;
    wire  [3:0]  o3;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb [4][$];

    assign res_w[0] = o0;
    assign res_w[1] = {24'h0, o1};
    assign res_w[2] = {20'h0, o2};
    assign res_w[3] = {28'h0, o3};

    always #5 clock = ~clock;

    // Edge counter used for latency checks.
    always @(posedge clock) cyc <= cyc + 1;

    bitwise_logic_serial #(.WIDTH(32), .CHUNK(8)) u0 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(rdy[0]),
        .num1(n1[0]), .num2(n2[0]), .op(opv[0]), .out_valid(ov[0]),
        .out_ready(out_ready), .out(o0), .zero(zr[0]));
    bitwise_logic_serial #(.WIDTH(8), .CHUNK(8)) u1 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(rdy[1]),
        .num1(n1[1][7:0]), .num2(n2[1][7:0]), .op(opv[1]), .out_valid(ov[1]),
        .out_ready(out_ready), .out(o1), .zero(zr[1]));
    bitwise_logic_serial #(.WIDTH(12), .CHUNK(4)) u2 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(rdy[2]),
        .num1(n1[2][11:0]), .num2(n2[2][11:0]), .op(opv[2]), .out_valid(ov[2]),
        .out_ready(out_ready), .out(o2), .zero(zr[2]));
    bitwise_logic_serial #(.WIDTH(4), .CHUNK(1)) u3 (
        .clock(clock), .reset_n(reset_n), .in_valid(iv[3]), .in_ready(rdy[3]),
        .num1(n1[3][3:0]), .num2(n2[3][3:0]), .op(opv[3]), .out_valid(ov[3]),
        .out_ready(out_ready), .out(o3), .zero(zr[3]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Present one operation, wait for its accept edge and queue the expectation.
    task automatic drive(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] o, input logic [31:0] res, input int n,
                         output int k);
        int w;
        w = 0;
        while (!rdy[idx] && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!rdy[idx]) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout inst=%0d actual=in_ready_low required=in_ready_high", idx);
            k = -1;
        end else begin
            n1[idx]  = a;
            n2[idx]  = b;
            opv[idx] = o;
            iv[idx]  = 1'b1;
            @(posedge clock);
            @(negedge clock);
            iv[idx] = 1'b0;
            n1[idx] = ~a;
            n2[idx] = 32'h0;
            k = cyc;
            sb[idx].push_back('{res: res, z: (res == 32'h0), due: 32'(cyc + n)});
        end
    endtask

    task automatic wait_ready(input int idx);
        int w;
        w = 0;
        while (!rdy[idx] && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!rdy[idx]) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout inst=%0d actual=busy required=idle", idx);
        end
    endtask

    // Monitor: on each rising out_valid pop and compare result, flag and latency.
    initial begin
        logic pv [4];
        exp_t e;
        for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 4; i++) begin
                if (ov[i] && !pv[i]) begin
                    if (sb[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_result inst=%0d actual=0x%0h required=none", i, res_w[i]);
                    end else begin
                        e = sb[i].pop_front();
                        chk($sformatf("result_%0d", i), res_w[i], e.res);
                        chk($sformatf("zero_%0d", i), {31'h0, zr[i]}, {31'h0, e.z});
                        chk($sformatf("latency_%0d", i), 32'(cyc), e.due);
                    end
                end
                pv[i] = ov[i];
            end
        end
    end

    initial begin
        int k1;
        int k2;
        for (int i = 0; i < 4; i++) begin
            n1[i] = 32'h0; n2[i] = 32'h0; opv[i] = 2'b00; iv[i] = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_out", o0, 32'h0);
        chk("rst_zero", {31'h0, zr[0]}, 32'h0);
        chk("rst_valid", {31'h0, ov[0]}, 32'h0);
        chk("rst_in_ready", {31'h0, rdy[0]}, 32'h0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_in_ready", {31'h0, rdy[0]}, 32'h1);

        // AND, in_ready low through RUN and DONE
        drive(0, 32'hF0F01234, 32'h0FF0FFFF, 2'b00, 32'h00F01234, 4, k1);
        for (int i = 0; i <= 4; i++) begin
            chk($sformatf("busy_in_ready_%0d", i), {31'h0, rdy[0]}, 32'h0);
            if (i < 4) @(negedge clock);
        end

        // XOR zero detect
        drive(0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b10, 32'h00000000, 4, k1);

        // OR then ANDN back-to-back
        drive(0, 32'h12340000, 32'h00005678, 2'b01, 32'h12345678, 4, k1);
        drive(0, 32'hFFFF0000, 32'h0F0F0F0F, 2'b11, 32'hF0F00000, 4, k2);
        chk("b2b_spacing", 32'(k2 - k1), 32'd6);

        // Backpressure in DONE with ignored in_valid pulses
        wait_ready(0);
        out_ready = 1'b0;
        drive(0, 32'h12345678, 32'hFF00FF00, 2'b00, 32'h12005600, 4, k1);
        repeat (4) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'h0, ov[0]}, 32'h1);
            chk("bp_out", o0, 32'h12005600);
            chk("bp_zero", {31'h0, zr[0]}, 32'h0);
            n1[0] = 32'h0; n2[0] = 32'h0; opv[0] = 2'b10;
            iv[0] = (i % 2 == 0);
            @(negedge clock);
        end
        iv[0] = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("drain_valid", {31'h0, ov[0]}, 32'h0);
        chk("drain_in_ready", {31'h0, rdy[0]}, 32'h1);
        chk("drain_out_hold", o0, 32'h12005600);

        // Reset while the counter is 2
        drive(0, 32'hFFFFFFFF, 32'h00000000, 2'b01, 32'hFFFFFFFF, 4, k1);
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        sb[0].delete();
        @(negedge clock);
        chk("midrst_valid", {31'h0, ov[0]}, 32'h0);
        chk("midrst_out", o0, 32'h0);
        chk("midrst_zero", {31'h0, zr[0]}, 32'h0);
        chk("midrst_in_ready", {31'h0, rdy[0]}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(0, 32'hFFFFFFFF, 32'h0000FFFF, 2'b00, 32'h0000FFFF, 4, k1);

        // Parameter sweep
        drive(1, 32'hC3, 32'h0F, 2'b00, 32'h03, 1, k1);
        drive(2, 32'hABC, 32'hFFF, 2'b10, 32'h543, 3, k1);
        drive(3, 32'h9, 32'h6, 2'b01, 32'hF, 4, k1);

        // Let every queued expectation drain
        for (int w = 0; w < 100; w++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0 && sb[2].size() == 0 && sb[3].size() == 0)
                break;
            @(negedge clock);
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 4; i++)
            chk($sformatf("sb_empty_%0d", i), 32'(sb[i].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
